// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM state encoding,
// RV32 major opcodes, and the datapath mux select encodings driven by the
// controller. No ports.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_LUI      = 4'd11,
      S_AUIPC    = 4'd12,
      S_ILLEGAL  = 4'd13
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT  = 2'b00;
   localparam logic [1:0] RES_MEMDATA = 2'b01;
   localparam logic [1:0] RES_ALURES  = 2'b10;

   localparam logic [2:0] IMM_NONE = 3'b000;
   localparam logic [2:0] IMM_I    = 3'b001;
   localparam logic [2:0] IMM_S    = 3'b010;
   localparam logic [2:0] IMM_B    = 3'b011;
   localparam logic [2:0] IMM_U    = 3'b100;
   localparam logic [2:0] IMM_J    = 3'b101;

endpackage

// File: rtl/mc_imm_sel.sv
// Immediate format select, decoded combinationally from the opcode.
// Ports:
//   op       in  7  opcode from the instruction register
//   imm_src  out 3  immediate format (none/I/S/B/U/J); unknown opcodes give none
module mc_imm_sel
   import mc_ctrl_pkg::*;
(
   input  logic [6:0] op,
   output logic [2:0] imm_src
);

   always_comb begin
      imm_src = IMM_NONE;
      case (op)
         OP_LOAD, OP_ITYPE: imm_src = IMM_I;
         OP_STORE:          imm_src = IMM_S;
         OP_BRANCH:         imm_src = IMM_B;
         OP_LUI, OP_AUIPC:  imm_src = IMM_U;
         OP_JAL:            imm_src = IMM_J;
         default:           imm_src = IMM_NONE;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV32 datapath. Sequences fetch, decode,
// memory, ALU, branch and jump steps and drives the datapath mux selects
// and write enables. Unsupported opcodes park the FSM in ILLEGAL until reset.
//
// Optional build macro RETIRE_CNT_EN adds a 32-bit retired-instruction counter.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   op[6:0]             opcode from instruction register
//   zero                ALU zero flag (branch decision)
//   mem_ready           memory completes current request
//   mem_req, AdrSrc     memory request, address select (0=PC, 1=ALUOut)
//   IRWrite, PCWrite, RegWrite, MemWrite   write enables
//   ALUSrcA, ALUSrcB, ALUOp, ImmSrc, ResultSrc   datapath selects
//   illegal             sticky illegal-opcode flag
//   state[3:0]          current FSM state (debug)
//   retired_cnt[31:0]   retired instruction count (RETIRE_CNT_EN only)
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 computed; waits for mem_ready
// DECODE   | read regs, compute OldPC+imm (branch/jal target)
// MEMADR   | rs1+imm address for load/store
// MEMREAD  | load request; waits for mem_ready
// MEMWB    | write load data to rd
// MEMWRITE | store request; waits for mem_ready
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | write ALUOut to rd
// BRANCH   | compare rs1/rs2, take target when zero
// JAL      | PC <- target, compute OldPC+4 for link
// LUI      | 0+imm
// AUIPC    | OldPC+imm
// ILLEGAL  | unsupported opcode; terminal until reset
module multicycle_controller
   import mc_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  op,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        AdrSrc,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        RegWrite,
   output logic        MemWrite,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ALUOp,
   output logic [2:0]  ImmSrc,
   output logic [1:0]  ResultSrc,
   output logic        illegal,
   output logic [3:0]  state
`ifdef RETIRE_CNT_EN
   ,
   output logic [31:0] retired_cnt
`endif
);

   state_t     state_q;
   logic       illegal_q;
   logic [2:0] imm_dec;
   logic       mem_req_i;
   logic       fetch_done;
   logic       pc_write_i;

   mc_imm_sel u_imm_sel (
      .op      (op),
      .imm_src (imm_dec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH:    if (mem_ready) state_q <= S_DECODE;
            S_DECODE: begin
               case (op)
                  OP_LOAD, OP_STORE: state_q <= S_MEMADR;
                  OP_RTYPE:          state_q <= S_EXECR;
                  OP_ITYPE:          state_q <= S_EXECI;
                  OP_BRANCH:         state_q <= S_BRANCH;
                  OP_JAL:            state_q <= S_JAL;
                  OP_LUI:            state_q <= S_LUI;
                  OP_AUIPC:          state_q <= S_AUIPC;
                  default: begin
                     state_q   <= S_ILLEGAL;
                     illegal_q <= 1'b1;
                  end
               endcase
            end
            S_MEMADR:   state_q <= (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_q <= S_MEMWB;
            S_MEMWB:    state_q <= S_FETCH;
            S_MEMWRITE: if (mem_ready) state_q <= S_FETCH;
            S_EXECR,
            S_EXECI:    state_q <= S_ALUWB;
            S_ALUWB:    state_q <= S_FETCH;
            S_BRANCH:   state_q <= S_FETCH;
            S_JAL:      state_q <= S_ALUWB;
            S_LUI,
            S_AUIPC:    state_q <= S_ALUWB;
            S_ILLEGAL:  state_q <= S_ILLEGAL;
            default:    state_q <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      mem_req_i  = 1'b0;
      fetch_done = 1'b0;
      pc_write_i = 1'b0;
      AdrSrc     = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RS2;
      ALUOp      = ALUOP_ADD;
      ResultSrc  = RES_ALUOUT;
      case (state_q)
         S_FETCH: begin
            mem_req_i  = 1'b1;
            ALUSrcB    = SRCB_FOUR;
            ResultSrc  = RES_ALURES;
            fetch_done = mem_ready;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD: begin
            mem_req_i = 1'b1;
            AdrSrc    = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = RES_MEMDATA;
            RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req_i = 1'b1;
            AdrSrc    = 1'b1;
            MemWrite  = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA = SRCA_RS1;
            ALUOp   = ALUOP_FUNCT;
         end
         S_EXECI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_FUNCT;
         end
         S_ALUWB:  RegWrite = 1'b1;
         S_BRANCH: begin
            ALUSrcA    = SRCA_RS1;
            ALUOp      = ALUOP_SUB;
            pc_write_i = zero;
         end
         S_JAL: begin
            ALUSrcA    = SRCA_OLDPC;
            ALUSrcB    = SRCB_FOUR;
            pc_write_i = 1'b1;
         end
         S_LUI: begin
            ALUSrcA = SRCA_ZERO;
            ALUSrcB = SRCB_IMM;
         end
         S_AUIPC: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         default: ;
      endcase
   end

   // The request is gated by rst_n so that a reset arriving mid-transfer
   // drops mem_req immediately instead of leaving a FETCH request pending.
   assign mem_req = mem_req_i & rst_n;
   assign IRWrite = fetch_done & rst_n;
   assign PCWrite = (fetch_done | pc_write_i) & rst_n;
   assign ImmSrc  = (state_q == S_FETCH) ? IMM_NONE : imm_dec;
   assign illegal = illegal_q;
   assign state   = state_q;

`ifdef RETIRE_CNT_EN
   logic [31:0] retired_cnt_q;
   logic        retire;

   assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) ||
                   (state_q == S_BRANCH) ||
                   ((state_q == S_MEMWRITE) && mem_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      retired_cnt_q <= 32'd0;
      else if (retire) retired_cnt_q <= retired_cnt_q + 32'd1;
   end

   assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller. The stimulus process pushes the
// expected output vector for each cycle; a monitor pops and compares at the
// falling edge (or on an explicit kick for asynchronous-reset checks).
module tb_multicycle_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  op;
   logic        zero;
   logic        mem_ready;
   logic        mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite;
   logic [1:0]  ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
   logic [2:0]  ImmSrc;
   logic        illegal;
   logic [3:0]  state;
`ifdef RETIRE_CNT_EN
   logic [31:0] retired_cnt;
`endif

   always #5 clk = ~clk;

   multicycle_controller dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .op        (op),
      .zero      (zero),
      .mem_ready (mem_ready),
      .mem_req   (mem_req),
      .AdrSrc    (AdrSrc),
      .IRWrite   (IRWrite),
      .PCWrite   (PCWrite),
      .RegWrite  (RegWrite),
      .MemWrite  (MemWrite),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ALUOp     (ALUOp),
      .ImmSrc    (ImmSrc),
      .ResultSrc (ResultSrc),
      .illegal   (illegal),
      .state     (state)
`ifdef RETIRE_CNT_EN
      ,
      .retired_cnt (retired_cnt)
`endif
   );

   // {mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
   //  ALUSrcA, ALUSrcB, ALUOp, ImmSrc, ResultSrc, illegal, state}
   logic [21:0] act;
   assign act = {mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
                 ALUSrcA, ALUSrcB, ALUOp, ImmSrc, ResultSrc, illegal, state};

   logic [21:0] exp_q[$];
   string       name_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   event        mon_kick;

   function automatic logic [21:0] mk(
      input logic mq, input logic ad, input logic ir, input logic pw,
      input logic rw, input logic mw, input logic [1:0] a, input logic [1:0] b,
      input logic [1:0] o, input logic [2:0] im, input logic [1:0] rs,
      input logic il, input logic [3:0] st);
      return {mq, ad, ir, pw, rw, mw, a, b, o, im, rs, il, st};
   endfunction

   initial begin
      logic [21:0] e;
      string       nm;
      forever begin
         @(negedge clk or mon_kick);
         while (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (act !== e) begin
               n_err++;
               $display("FAIL %s: got %h expected %h (state got %0d want %0d)",
                        nm, act, e, act[3:0], e[3:0]);
            end
         end
      end
   end

   task automatic step(input logic [21:0] e, input string n);
      exp_q.push_back(e);
      name_q.push_back(n);
      @(posedge clk);
      #1;
   endtask

   // Reset / FETCH-stall / FETCH-complete vectors
   function automatic logic [21:0] v_rst();
      return mk(0,0,0,0,0,0, 2'b00,2'b10,2'b00, 3'b000, 2'b10, 0, 4'd0);
   endfunction
   function automatic logic [21:0] v_fetch(input logic done);
      return mk(1,0,done,done,0,0, 2'b00,2'b10,2'b00, 3'b000, 2'b10, 0, 4'd0);
   endfunction
   function automatic logic [21:0] v_dec(input logic [2:0] im);
      return mk(0,0,0,0,0,0, 2'b01,2'b01,2'b00, im, 2'b00, 0, 4'd1);
   endfunction
   function automatic logic [21:0] v_aluwb(input logic [2:0] im);
      return mk(0,0,0,0,1,0, 2'b00,2'b00,2'b00, im, 2'b00, 0, 4'd8);
   endfunction

   task automatic run_add(input string tag);
      op = 7'b0110011;
      step(v_fetch(1), {tag, ".fetch"});
      step(v_dec(3'b000), {tag, ".decode"});
      step(mk(0,0,0,0,0,0, 2'b10,2'b00,2'b10, 3'b000, 2'b00, 0, 4'd6), {tag, ".execr"});
      step(v_aluwb(3'b000), {tag, ".aluwb"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; op = 7'b0110011; zero = 1'b0; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      step(v_rst(), "reset.held");
      rst_n = 1'b1;

      run_add("add");

      // lw: FETCH stalls once, MEMREAD waits 3 cycles
      op = 7'b0000011; mem_ready = 1'b0;
      step(v_fetch(0), "lw.fetch_wait");
      mem_ready = 1'b1;
      step(v_fetch(1), "lw.fetch");
      step(v_dec(3'b001), "lw.decode");
      step(mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00, 3'b001, 2'b00, 0, 4'd2), "lw.memadr");
      mem_ready = 1'b0;
      repeat (2) step(mk(1,1,0,0,0,0, 2'b00,2'b00,2'b00, 3'b001, 2'b00, 0, 4'd3), "lw.memread_wait");
      mem_ready = 1'b1;
      step(mk(1,1,0,0,0,0, 2'b00,2'b00,2'b00, 3'b001, 2'b00, 0, 4'd3), "lw.memread_done");
      step(mk(0,0,0,0,1,0, 2'b00,2'b00,2'b00, 3'b001, 2'b01, 0, 4'd4), "lw.memwb");

      // sw with zero-wait completion
      op = 7'b0100011;
      step(v_fetch(1), "sw.fetch");
      step(v_dec(3'b010), "sw.decode");
      step(mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00, 3'b010, 2'b00, 0, 4'd2), "sw.memadr");
      step(mk(1,1,0,0,0,1, 2'b00,2'b00,2'b00, 3'b010, 2'b00, 0, 4'd5), "sw.memwrite");

      // addi
      op = 7'b0010011;
      step(v_fetch(1), "addi.fetch");
      step(v_dec(3'b001), "addi.decode");
      step(mk(0,0,0,0,0,0, 2'b10,2'b01,2'b10, 3'b001, 2'b00, 0, 4'd7), "addi.execi");
      step(v_aluwb(3'b001), "addi.aluwb");

      // beq taken then not taken
      op = 7'b1100011; zero = 1'b1;
      step(v_fetch(1), "beq1.fetch");
      step(v_dec(3'b011), "beq1.decode");
      step(mk(0,0,0,1,0,0, 2'b10,2'b00,2'b01, 3'b011, 2'b00, 0, 4'd9), "beq1.branch");
      zero = 1'b0;
      step(v_fetch(1), "beq0.fetch");
      step(v_dec(3'b011), "beq0.decode");
      step(mk(0,0,0,0,0,0, 2'b10,2'b00,2'b01, 3'b011, 2'b00, 0, 4'd9), "beq0.branch");

      // jal
      op = 7'b1101111;
      step(v_fetch(1), "jal.fetch");
      step(v_dec(3'b101), "jal.decode");
      step(mk(0,0,0,1,0,0, 2'b01,2'b10,2'b00, 3'b101, 2'b00, 0, 4'd10), "jal.jal");
      step(v_aluwb(3'b101), "jal.aluwb");

      // lui, auipc
      op = 7'b0110111;
      step(v_fetch(1), "lui.fetch");
      step(v_dec(3'b100), "lui.decode");
      step(mk(0,0,0,0,0,0, 2'b11,2'b01,2'b00, 3'b100, 2'b00, 0, 4'd11), "lui.lui");
      step(v_aluwb(3'b100), "lui.aluwb");
      op = 7'b0010111;
      step(v_fetch(1), "auipc.fetch");
      step(v_dec(3'b100), "auipc.decode");
      step(mk(0,0,0,0,0,0, 2'b01,2'b01,2'b00, 3'b100, 2'b00, 0, 4'd12), "auipc.auipc");
      step(v_aluwb(3'b100), "auipc.aluwb");

      // sw stalled, reset dropped during the wait
      op = 7'b0100011;
      step(v_fetch(1), "sw2.fetch");
      step(v_dec(3'b010), "sw2.decode");
      step(mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00, 3'b010, 2'b00, 0, 4'd2), "sw2.memadr");
      mem_ready = 1'b0;
      step(mk(1,1,0,0,0,1, 2'b00,2'b00,2'b00, 3'b010, 2'b00, 0, 4'd5), "sw2.memwrite_wait");
      rst_n = 1'b0;
      #1;
      exp_q.push_back(v_rst());
      name_q.push_back("rst.async_in_memwrite");
      -> mon_kick;
      #1;
      mem_ready = 1'b1;
      step(v_rst(), "rst.held_after_memwrite");
      rst_n = 1'b1;
      run_add("add_after_rst");

      // jalr opcode is unsupported: terminal ILLEGAL
      op = 7'b1100111; zero = 1'b1;
      step(v_fetch(1), "ill.fetch");
      step(v_dec(3'b000), "ill.decode");
      repeat (10)
         step(mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 1, 4'd13), "ill.hold");
      rst_n = 1'b0;
      #1;
      exp_q.push_back(v_rst());
      name_q.push_back("ill.rst_async");
      -> mon_kick;
      #1;
      rst_n = 1'b1;
      zero = 1'b0;
      run_add("add_after_ill");

`ifdef RETIRE_CNT_EN
      op = 7'b0110011;
      force dut.retired_cnt_q = 32'hFFFF_FFFF;
      step(v_fetch(1), "wrap.fetch");
      release dut.retired_cnt_q;
      step(v_dec(3'b000), "wrap.decode");
      step(mk(0,0,0,0,0,0, 2'b10,2'b00,2'b10, 3'b000, 2'b00, 0, 4'd6), "wrap.execr");
      step(v_aluwb(3'b000), "wrap.aluwb");
      n_cmp++;
      if (retired_cnt !== 32'd0) begin
         n_err++;
         $display("FAIL retired_cnt_wrap: got %h expected 00000000", retired_cnt);
      end
`endif

      @(negedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have ports, in order: clk  in  1  sole clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: op  in  7  opcode from instruction register; zero  in  1  ALU zero flag; mem_ready  in  1  memory completes current request.
REQ-003 SHALL have outputs: mem_req  1; AdrSrc  1 (0=PC, 1=ALUOut); IRWrite  1; PCWrite  1; RegWrite  1; MemWrite  1.
REQ-004 SHALL have outputs: ALUSrcA  2 (00=PC, 01=OldPC, 10=rs1, 11=zero); ALUSrcB  2 (00=rs2, 01=imm, 10=const 4); ALUOp  2; ImmSrc  3 (000 none, 001 I, 010 S, 011 B, 100 U, 101 J); ResultSrc  2 (00=ALUOut, 01=mem data, 10=ALU result).
REQ-005 SHALL have outputs: illegal  1  sticky illegal-opcode flag; state  4  current FSM state for debug.

Function
REQ-006 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, AUIPC, ILLEGAL.
REQ-007 FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; hold until mem_ready; IRWrite=PCWrite=1 only in the cycle mem_ready=1, then DECODE.
REQ-008 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; next state by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, 0110111->LUI, 0010111->AUIPC, any other value (1100111 included)->ILLEGAL.
REQ-009 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; next MEMREAD if op=0000011, else MEMWRITE.
REQ-010 MEMREAD: mem_req=1, AdrSrc=1; hold until mem_ready, then MEMWB. MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
REQ-011 MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1 every waiting cycle; hold until mem_ready, then FETCH.
REQ-012 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Both go to ALUWB. ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
REQ-013 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero; then FETCH.
REQ-014 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1; then ALUWB, which writes OldPC+4.
REQ-015 LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00. AUIPC: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Both go to ALUWB.
REQ-016 ImmSrc SHALL decode combinationally from op in every state except FETCH, where it is 000; unknown op gives 000.
REQ-017 ILLEGAL SHALL be terminal until reset: illegal=1; mem_req, IRWrite, PCWrite, RegWrite, MemWrite all 0.
REQ-018 Any output not listed for a state SHALL be 0.
REQ-019 mem_ready SHALL be ignored in states with mem_req=0. Zero-wait completion (mem_ready already high on state entry) SHALL finish in one cycle.
REQ-020 op SHALL be sampled only in DECODE, MEMADR and combinational ImmSrc; no op register.

Reset
REQ-021 rst_n low SHALL force state=FETCH and illegal=0 asynchronously; outputs take FETCH values, with IRWrite=PCWrite=0 while rst_n is low.
REQ-022 Reset asserted mid-request SHALL abandon the request; the first cycle after release starts a fresh FETCH.

Configuration
REQ-023 With RETIRE_CNT_EN defined, the block SHALL add output retired_cnt  out  32. It resets to 0 and increments once per instruction on leaving MEMWB, ALUWB, BRANCH, or MEMWRITE with mem_ready. It wraps 0xFFFFFFFF->0. Without the macro, the port and counter SHALL NOT exist.

Structure
REQ-024 Package mc_ctrl_pkg SHALL hold the state enum (4-bit), the opcode constants, and the ALUSrcA/ALUSrcB/ResultSrc/ImmSrc encodings.
REQ-025 One sub-module, mc_imm_sel (op->ImmSrc, combinational), SHALL be instantiated. The FSM and output logic stay in the top module.

Verification
REQ-026 add (op=0110011), mem_ready constant 1 -> FETCH,DECODE,EXECR,ALUWB: 4 cycles; RegWrite=1 only in ALUWB.
REQ-027 lw (op=0000011), mem_ready delayed 3 cycles in MEMREAD -> AdrSrc=1 and mem_req=1 held 3 cycles; MEMWB with ResultSrc=01; 7 cycles total.
REQ-028 beq (op=1100011) with zero=1, then again with zero=0 -> PCWrite=1 in BRANCH for the first, 0 for the second; both return to FETCH.
REQ-029 op=1100111 -> ILLEGAL after DECODE, illegal=1 and all write enables 0 for 10 cycles; rst_n pulse -> FETCH, illegal=0.
REQ-030 rst_n dropped during MEMWRITE wait -> MemWrite and mem_req fall without a clock edge. With RETIRE_CNT_EN defined, retired_cnt preset to 0xFFFFFFFF plus one add -> 0.
